trigger_chain_wb_initiator: RTL and testbench

//  Wishbone initiator driving the trigger chain's two register targets:

---
 rtl/trigger_chain_wb_initiator.sv | 211 +++++++++++++++++++++
 tb/tb_trigger_chain_wb_initiator.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_chain_wb_initiator.sv
// Wishbone classic initiator for the trigger chain's biquad and AGC register targets.
// One command in, one bus cycle (with retries/timeout), one response out.
module trigger_chain_wb_initiator #(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_tgt_i,
    input  logic        cmd_we_i,
    input  logic [7:0]  cmd_adr_i,
    input  logic [31:0] cmd_dat_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        busy_o,

    output logic        wb_bq_cyc_o,
    output logic        wb_bq_stb_o,
    output logic        wb_bq_we_o,
    output logic [7:0]  wb_bq_adr_o,
    output logic [31:0] wb_bq_dat_o,
    output logic [3:0]  wb_bq_sel_o,
    input  logic [31:0] wb_bq_dat_i,
    input  logic        wb_bq_ack_i,
    input  logic        wb_bq_err_i,
    input  logic        wb_bq_rty_i,

    output logic        wb_agc_cyc_o,
    output logic        wb_agc_stb_o,
    output logic        wb_agc_we_o,
    output logic [7:0]  wb_agc_adr_o,
    output logic [31:0] wb_agc_dat_o,
    output logic [3:0]  wb_agc_sel_o,
    input  logic [31:0] wb_agc_dat_i,
    input  logic        wb_agc_ack_i,
    input  logic        wb_agc_err_i,
    input  logic        wb_agc_rty_i
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] T_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP,
        RESP
    } state_t;

    state_t         state;
    logic           cmd_ready_q;
    logic           busy_q;
    logic           bus_act;
    logic           tgt_q;
    logic           we_q;
    logic [7:0]     adr_q;
    logic [31:0]    dat_q;
    logic [TW-1:0]  tmo_cnt;
    logic [RW-1:0]  rty_cnt;
    logic           rsp_valid_q;
    logic [31:0]    rsp_dat_q;
    logic           rsp_err_q;
    logic           rsp_to_q;

    logic           sel_ack;
    logic           sel_err;
    logic           sel_rty;
    logic [31:0]    sel_dat;
    logic           bq_on;
    logic           agc_on;

    // Only the latched target's termination lines are looked at.
    assign sel_ack = tgt_q ? wb_agc_ack_i : wb_bq_ack_i;
    assign sel_err = tgt_q ? wb_agc_err_i : wb_bq_err_i;
    assign sel_rty = tgt_q ? wb_agc_rty_i : wb_bq_rty_i;
    assign sel_dat = tgt_q ? wb_agc_dat_i : wb_bq_dat_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            bus_act     <= 1'b0;
            tgt_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            tmo_cnt     <= '0;
            rty_cnt     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid_i && cmd_ready_q) begin
                        tgt_q       <= cmd_tgt_i;
                        we_q        <= cmd_we_i;
                        adr_q       <= cmd_adr_i;
                        dat_q       <= cmd_dat_i;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        bus_act     <= 1'b1;
                        tmo_cnt     <= '0;
                        rty_cnt     <= '0;
                        state       <= BUS;
                    end
                end

                // Termination priority is ack > err > rty; any termination beats the timeout.
                BUS: begin
                    if (sel_ack) begin
                        bus_act     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= we_q ? 32'h0 : sel_dat;
                        rsp_err_q   <= 1'b0;
                        rsp_to_q    <= 1'b0;
                        state       <= RESP;
                    end else if (sel_err) begin
                        bus_act     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= 32'h0;
                        rsp_err_q   <= 1'b1;
                        rsp_to_q    <= 1'b0;
                        state       <= RESP;
                    end else if (sel_rty) begin
                        bus_act <= 1'b0;
                        if (rty_cnt < R_MAX) begin
                            state <= GAP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_dat_q   <= 32'h0;
                            rsp_err_q   <= 1'b1;
                            rsp_to_q    <= 1'b0;
                            state       <= RESP;
                        end
                    end else if ((TIMEOUT != 0) && (tmo_cnt == T_LAST)) begin
                        bus_act     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= 32'h0;
                        rsp_err_q   <= 1'b0;
                        rsp_to_q    <= 1'b1;
                        state       <= RESP;
                    end else if (TIMEOUT != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                GAP: begin
                    rty_cnt <= rty_cnt + 1'b1;
                    tmo_cnt <= '0;
                    bus_act <= 1'b1;
                    state   <= BUS;
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_dat_q   <= 32'h0;
                        rsp_err_q   <= 1'b0;
                        rsp_to_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are gated by the target select so the idle target always sees zeros.
    assign bq_on  = bus_act & ~tgt_q;
    assign agc_on = bus_act &  tgt_q;

    assign wb_bq_cyc_o  = bq_on;
    assign wb_bq_stb_o  = bq_on;
    assign wb_bq_we_o   = bq_on & we_q;
    assign wb_bq_adr_o  = bq_on ? adr_q : 8'h00;
    assign wb_bq_dat_o  = bq_on ? dat_q : 32'h0;
    assign wb_bq_sel_o  = bq_on ? 4'hF : 4'h0;

    assign wb_agc_cyc_o = agc_on;
    assign wb_agc_stb_o = agc_on;
    assign wb_agc_we_o  = agc_on & we_q;
    assign wb_agc_adr_o = agc_on ? adr_q : 8'h00;
    assign wb_agc_dat_o = agc_on ? dat_q : 32'h0;
    assign wb_agc_sel_o = agc_on ? 4'hF : 4'h0;

    assign cmd_ready_o   = cmd_ready_q;
    assign busy_o        = busy_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_to_q;

endmodule

// File: tb/tb_trigger_chain_wb_initiator.sv
// Directed, table-driven bench for trigger_chain_wb_initiator with a cycle-level target model
// that also drives noise on the unselected target.
module tb_trigger_chain_wb_initiator;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_tgt_i;
    logic        cmd_we_i;
    logic [7:0]  cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        busy_o;
    logic        wb_bq_cyc_o, wb_bq_stb_o, wb_bq_we_o;
    logic [7:0]  wb_bq_adr_o;
    logic [31:0] wb_bq_dat_o;
    logic [3:0]  wb_bq_sel_o;
    logic [31:0] wb_bq_dat_i;
    logic        wb_bq_ack_i, wb_bq_err_i, wb_bq_rty_i;
    logic        wb_agc_cyc_o, wb_agc_stb_o, wb_agc_we_o;
    logic [7:0]  wb_agc_adr_o;
    logic [31:0] wb_agc_dat_o;
    logic [3:0]  wb_agc_sel_o;
    logic [31:0] wb_agc_dat_i;
    logic        wb_agc_ack_i, wb_agc_err_i, wb_agc_rty_i;

    int checks = 0;
    int errors = 0;

    trigger_chain_wb_initiator #(.TIMEOUT(255), .MAX_RETRY(3)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_tgt_i     (cmd_tgt_i),
        .cmd_we_i      (cmd_we_i),
        .cmd_adr_i     (cmd_adr_i),
        .cmd_dat_i     (cmd_dat_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_dat_o     (rsp_dat_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o),
        .wb_bq_cyc_o   (wb_bq_cyc_o),
        .wb_bq_stb_o   (wb_bq_stb_o),
        .wb_bq_we_o    (wb_bq_we_o),
        .wb_bq_adr_o   (wb_bq_adr_o),
        .wb_bq_dat_o   (wb_bq_dat_o),
        .wb_bq_sel_o   (wb_bq_sel_o),
        .wb_bq_dat_i   (wb_bq_dat_i),
        .wb_bq_ack_i   (wb_bq_ack_i),
        .wb_bq_err_i   (wb_bq_err_i),
        .wb_bq_rty_i   (wb_bq_rty_i),
        .wb_agc_cyc_o  (wb_agc_cyc_o),
        .wb_agc_stb_o  (wb_agc_stb_o),
        .wb_agc_we_o   (wb_agc_we_o),
        .wb_agc_adr_o  (wb_agc_adr_o),
        .wb_agc_dat_o  (wb_agc_dat_o),
        .wb_agc_sel_o  (wb_agc_sel_o),
        .wb_agc_dat_i  (wb_agc_dat_i),
        .wb_agc_ack_i  (wb_agc_ack_i),
        .wb_agc_err_i  (wb_agc_err_i),
        .wb_agc_rty_i  (wb_agc_rty_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // term bits are {ack, err, rty}; the target terminates on stb cycle wait_n+1 of every burst.
    typedef struct {
        string       name;
        logic        tgt;
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        int          wait_n;
        logic [2:0]  term;
        logic [31:0] rdat;
        int          hold;
        logic [31:0] exp_dat;
        logic        exp_err;
        logic        exp_to;
        int          exp_stb;
        int          exp_bursts;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveTarget(input logic tgt, input logic [2:0] term, input logic [31:0] rdat);
        if (tgt == 1'b0) begin
            {wb_bq_ack_i, wb_bq_err_i, wb_bq_rty_i} = term;
            wb_bq_dat_i = rdat;
            {wb_agc_ack_i, wb_agc_err_i, wb_agc_rty_i} = 3'b111;
            wb_agc_dat_i = 32'hBADBAD00;
        end else begin
            {wb_agc_ack_i, wb_agc_err_i, wb_agc_rty_i} = term;
            wb_agc_dat_i = rdat;
            {wb_bq_ack_i, wb_bq_err_i, wb_bq_rty_i} = 3'b111;
            wb_bq_dat_i = 32'hBADBAD00;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int   guard;
        int   cycles;
        int   stb_total;
        int   bursts;
        int   burst_cyc;
        logic prev_stb;
        logic cur_stb;
        logic dirty;
        logic stable;

        guard = 0;
        while (!cmd_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput({v.name, "/cmd_ready"}, cmd_ready_o, 1);

        cmd_valid_i = 1'b1;
        cmd_tgt_i   = v.tgt;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_dat_i   = v.dat;
        driveTarget(v.tgt, 3'b000, v.rdat);
        tick();
        cmd_valid_i = 1'b0;
        cmd_we_i    = ~v.we;
        cmd_adr_i   = 8'hEE;
        cmd_dat_i   = 32'h0;

        checkOutput({v.name, "/cyc_n1"}, v.tgt ? wb_agc_cyc_o : wb_bq_cyc_o, 1);
        checkOutput({v.name, "/adr"}, v.tgt ? wb_agc_adr_o : wb_bq_adr_o, v.adr);
        checkOutput({v.name, "/dat_o"}, v.tgt ? wb_agc_dat_o : wb_bq_dat_o, v.dat);
        checkOutput({v.name, "/we"}, v.tgt ? wb_agc_we_o : wb_bq_we_o, v.we);
        checkOutput({v.name, "/sel"}, v.tgt ? wb_agc_sel_o : wb_bq_sel_o, 4'hF);

        cycles    = 0;
        stb_total = 0;
        bursts    = 0;
        burst_cyc = 0;
        prev_stb  = 1'b0;
        dirty     = 1'b0;
        while (!rsp_valid_o && cycles < 600) begin
            cur_stb = v.tgt ? wb_agc_stb_o : wb_bq_stb_o;
            if (!busy_o || (v.tgt ? (wb_bq_cyc_o | wb_bq_stb_o | wb_bq_we_o | (|wb_bq_adr_o) |
                                     (|wb_bq_dat_o) | (|wb_bq_sel_o))
                                  : (wb_agc_cyc_o | wb_agc_stb_o | wb_agc_we_o | (|wb_agc_adr_o) |
                                     (|wb_agc_dat_o) | (|wb_agc_sel_o))))
                dirty = 1'b1;
            if (cur_stb) begin
                if (!prev_stb) begin
                    bursts++;
                    burst_cyc = 0;
                end
                burst_cyc++;
                stb_total++;
            end
            driveTarget(v.tgt, (cur_stb && burst_cyc == v.wait_n + 1) ? v.term : 3'b000, v.rdat);
            prev_stb = cur_stb;
            tick();
            cycles++;
        end
        driveTarget(v.tgt, 3'b000, v.rdat);

        checkOutput({v.name, "/rsp_valid"}, rsp_valid_o, 1);
        checkOutput({v.name, "/stb_cycles"}, stb_total, v.exp_stb);
        checkOutput({v.name, "/bursts"}, bursts, v.exp_bursts);
        checkOutput({v.name, "/latency"}, cycles, v.exp_stb + v.exp_bursts - 1);
        checkOutput({v.name, "/bus_hygiene"}, dirty, 0);
        checkOutput({v.name, "/bus_idle_at_rsp"}, {30'h0, wb_bq_cyc_o, wb_agc_cyc_o}, 0);
        checkOutput({v.name, "/rsp_dat"}, rsp_dat_o, v.exp_dat);
        checkOutput({v.name, "/rsp_err"}, rsp_err_o, v.exp_err);
        checkOutput({v.name, "/rsp_timeout"}, rsp_timeout_o, v.exp_to);

        if (v.hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                tick();
                if (!rsp_valid_o || rsp_dat_o !== v.exp_dat || rsp_err_o !== v.exp_err ||
                    rsp_timeout_o !== v.exp_to)
                    stable = 1'b0;
            end
            checkOutput({v.name, "/rsp_hold"}, stable, 1);
        end

        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checkOutput({v.name, "/rsp_released"}, rsp_valid_o, 0);
        checkOutput({v.name, "/idle_busy"}, busy_o, 0);
        checkOutput({v.name, "/idle_ready"}, cmd_ready_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic any_rsp;
        logic any_cyc;
        vec_t again;

        vecs[0] = '{"wr_bq_ack",    1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 0,    3'b100, 32'hAAAA5555, 0, 32'h0,        1'b0, 1'b0, 1,   1};
        vecs[1] = '{"rd_agc_wait3", 1'b1, 1'b0, 8'h04, 32'h0,        3,    3'b100, 32'h12345678, 5, 32'h12345678, 1'b0, 1'b0, 4,   1};
        vecs[2] = '{"rty_x4",       1'b0, 1'b1, 8'h20, 32'h00000001, 0,    3'b001, 32'h0,        0, 32'h0,        1'b1, 1'b0, 4,   4};
        vecs[3] = '{"timeout",      1'b1, 1'b0, 8'h08, 32'h0,        1000, 3'b000, 32'hFFFFFFFF, 0, 32'h0,        1'b0, 1'b1, 255, 1};
        vecs[4] = '{"ack_at_255",   1'b0, 1'b0, 8'h30, 32'h0,        254,  3'b100, 32'hCAFEF00D, 2, 32'hCAFEF00D, 1'b0, 1'b0, 255, 1};
        vecs[5] = '{"err_rd",       1'b1, 1'b0, 8'h7F, 32'h0,        1,    3'b010, 32'h11111111, 0, 32'h0,        1'b1, 1'b0, 2,   1};
        vecs[6] = '{"ack_err_same", 1'b1, 1'b0, 8'h55, 32'h0,        0,    3'b110, 32'h87654321, 1, 32'h87654321, 1'b0, 1'b0, 1,   1};
        vecs[7] = '{"ack_rty_same", 1'b1, 1'b1, 8'h66, 32'h0F0F0F0F, 2,    3'b101, 32'h0,        0, 32'h0,        1'b0, 1'b0, 3,   1};
        vecs[8] = '{"err_rty_same", 1'b0, 1'b0, 8'h12, 32'h0,        0,    3'b011, 32'h5A5A5A5A, 0, 32'h0,        1'b1, 1'b0, 1,   1};

        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_tgt_i   = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 8'h00;
        cmd_dat_i   = 32'h0;
        rsp_ready_i = 1'b0;
        driveTarget(1'b0, 3'b000, 32'h0);

        tick();
        tick();
        checkOutput("reset/cmd_ready", cmd_ready_o, 0);
        checkOutput("reset/rsp_valid", rsp_valid_o, 0);
        checkOutput("reset/busy", busy_o, 0);
        checkOutput("reset/cyc", {30'h0, wb_bq_cyc_o, wb_agc_cyc_o}, 0);
        wb_rst_i = 1'b0;
        tick();
        checkOutput("post_reset/cmd_ready", cmd_ready_o, 1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of an AGC cycle must drop it without a response.
        cmd_valid_i = 1'b1;
        cmd_tgt_i   = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 8'h44;
        cmd_dat_i   = 32'h01020304;
        driveTarget(1'b1, 3'b000, 32'h0);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        checkOutput("midbus/agc_cyc_before", wb_agc_cyc_o, 1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        checkOutput("midbus/agc_cyc", wb_agc_cyc_o, 0);
        checkOutput("midbus/agc_stb", wb_agc_stb_o, 0);
        checkOutput("midbus/busy", busy_o, 0);
        checkOutput("midbus/cmd_ready", cmd_ready_o, 0);
        tick();
        wb_rst_i = 1'b0;
        any_rsp = 1'b0;
        any_cyc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            driveTarget(1'b1, 3'b100, 32'h0);
            tick();
            any_rsp = any_rsp | rsp_valid_o;
            any_cyc = any_cyc | wb_agc_cyc_o | wb_bq_cyc_o;
        end
        checkOutput("midbus/no_rsp", any_rsp, 0);
        checkOutput("midbus/no_cyc", any_cyc, 0);

        again = vecs[1];
        again.name = "after_reset_rd";
        applyStimulus(again);
        again = vecs[0];
        again.name = "after_reset_wr";
        applyStimulus(again);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
